// File: rtl/router_gen2_pkg.sv
// Shared constants and helpers for the second-generation router packet register stage.
package router_gen2_pkg;

   localparam int CHECK_XOR = 0;
   localparam int CHECK_CRC = 1;

   localparam logic [7:0] DEFAULT_CRC_POLY = 8'h07;

   // Extracts a bit field of the given width starting at lsb from a header word.
   function automatic logic [31:0] hdr_field(input logic [31:0] hdr, input int lsb, input int width);
      logic [31:0] mask;
      if (width >= 32) begin
         mask = 32'hFFFF_FFFF;
      end else begin
         mask = (32'h1 << width) - 32'h1;
      end
      return (hdr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/router_chk_step.sv
// One trailer-check step: XOR accumulate, or one MSB-first CRC update over a whole byte.
module router_chk_step
   import router_gen2_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                CHECK_MODE = CHECK_XOR,
   parameter logic [DATA_W-1:0] CRC_POLY   = DATA_W'(DEFAULT_CRC_POLY)
)(
   input  logic [DATA_W-1:0] chk_cur,
   input  logic [DATA_W-1:0] byte_in,
   output logic [DATA_W-1:0] chk_next
);

   logic [DATA_W-1:0] crc_s;

   // Fold the byte in, then shift DATA_W times with the implicit x^DATA_W term.
   always_comb begin
      crc_s = chk_cur ^ byte_in;
      if (CHECK_MODE == CHECK_CRC) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (crc_s[DATA_W-1]) begin
               crc_s = {crc_s[DATA_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
               crc_s = {crc_s[DATA_W-2:0], 1'b0};
            end
         end
      end else begin
         crc_s = chk_cur ^ byte_in;
      end
      chk_next = crc_s;
   end

endmodule

// File: rtl/router_reg_gen2.sv
// Router packet register stage: header capture, full-FIFO byte replay,
// trailer check (XOR or CRC), payload-length check and saturating error count.
module router_reg_gen2
   import router_gen2_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 2,
   parameter int                NUM_PORTS  = 3,
   parameter int                CHECK_MODE = CHECK_XOR,
   parameter logic [DATA_W-1:0] CRC_POLY   = DATA_W'(DEFAULT_CRC_POLY),
   parameter int                ERRCNT_W   = 8
)(
   input  logic                clock,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic                fifo_full,
   input  logic                detect_add,
   input  logic                lfd_state,
   input  logic                ld_state,
   input  logic                laf_state,
   input  logic                full_state,
   input  logic                rst_int_reg,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_valid,
   output logic                parity_done,
   output logic                low_packet_valid,
   output logic                err,
   output logic                len_err,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam int LEN_W = DATA_W - ADDR_W;
   localparam logic [LEN_W-1:0]    PAY_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [ERRCNT_W-1:0] CNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0]   hdr_q, hdr_d, chk_acc_q, chk_acc_d, trl_q, trl_d;
   logic [DATA_W-1:0]   full_byte_q, full_byte_d, dout_q, dout_d;
   logic [LEN_W-1:0]    pay_cnt_q, pay_cnt_d;
   logic [ERRCNT_W-1:0] err_count_q, err_count_d;
   logic dout_valid_q, dout_valid_d, parity_done_q, parity_done_d;
   logic pd_prev_q, pd_prev_d, lpv_q, lpv_d, err_q, err_d;
   logic len_err_q, len_err_d, laf_prev_q, laf_prev_d;

   logic [DATA_W-1:0] step_cur_s, step_byte_s, step_next_s;
   logic hdr_ok_s, pd_rise_s, chk_mis_s, len_mis_s;

   // lfd seeds the accumulator from zero with the stored header; otherwise fold data_in.
   assign step_cur_s  = lfd_state ? {DATA_W{1'b0}} : chk_acc_q;
   assign step_byte_s = lfd_state ? hdr_q : data_in;

   router_chk_step #(
      .DATA_W     (DATA_W),
      .CHECK_MODE (CHECK_MODE),
      .CRC_POLY   (CRC_POLY)
   ) u_chk_step (
      .chk_cur  (step_cur_s),
      .byte_in  (step_byte_s),
      .chk_next (step_next_s)
   );

   assign hdr_ok_s  = hdr_field(32'(data_in), 0, ADDR_W) < 32'(NUM_PORTS);
   assign pd_rise_s = parity_done_q & ~pd_prev_q;
   assign chk_mis_s = (chk_acc_q != trl_q);
   assign len_mis_s = (pay_cnt_q != hdr_q[DATA_W-1:ADDR_W]);

   // Next-state logic for all packet registers and flags.
   always_comb begin
      hdr_d         = hdr_q;
      chk_acc_d     = chk_acc_q;
      pay_cnt_d     = pay_cnt_q;
      trl_d         = trl_q;
      full_byte_d   = full_byte_q;
      dout_d        = dout_q;
      dout_valid_d  = 1'b0;
      parity_done_d = parity_done_q;
      pd_prev_d     = parity_done_q;
      lpv_d         = lpv_q;
      err_d         = err_q;
      len_err_d     = len_err_q;
      err_count_d   = err_count_q;
      laf_prev_d    = 1'b0;

      if (pd_rise_s) begin
         err_d     = err_q | chk_mis_s;
         len_err_d = len_err_q | len_mis_s;
         if ((chk_mis_s || len_mis_s) && (err_count_q != {ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_ONE;
         end else begin
            err_count_d = err_count_q;
         end
      end else begin
         err_d = err_q;
      end

      if (detect_add) begin
         if (pkt_valid && hdr_ok_s) begin
            hdr_d         = data_in;
            chk_acc_d     = {DATA_W{1'b0}};
            pay_cnt_d     = {LEN_W{1'b0}};
            parity_done_d = 1'b0;
            err_d         = 1'b0;
            len_err_d     = 1'b0;
         end else begin
            hdr_d = hdr_q;
         end
      end else if (lfd_state) begin
         dout_d       = hdr_q;
         dout_valid_d = 1'b1;
         chk_acc_d    = step_next_s;
      end else if (ld_state) begin
         if (pkt_valid) begin
            chk_acc_d = step_next_s;
            if (pay_cnt_q != {LEN_W{1'b1}}) begin
               pay_cnt_d = pay_cnt_q + PAY_ONE;
            end else begin
               pay_cnt_d = pay_cnt_q;
            end
            if (fifo_full) begin
               full_byte_d = data_in;
            end else begin
               dout_d       = data_in;
               dout_valid_d = 1'b1;
            end
         end else begin
            // Trailer byte; with the FIFO full, completion waits for the replay cycle.
            trl_d = data_in;
            lpv_d = 1'b1;
            if (!fifo_full) begin
               parity_done_d = 1'b1;
            end else begin
               parity_done_d = parity_done_q;
            end
         end
      end else if (laf_state) begin
         dout_d       = full_byte_q;
         dout_valid_d = ~laf_prev_q;
         laf_prev_d   = 1'b1;
         if (lpv_q && !parity_done_q) begin
            parity_done_d = 1'b1;
         end else begin
            parity_done_d = parity_done_q;
         end
      end else begin
         dout_d = dout_q;
      end

      if (rst_int_reg) begin
         lpv_d = 1'b0;
      end else begin
         lpv_d = lpv_d;
      end
   end

   // State registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hdr_q         <= {DATA_W{1'b0}};
         chk_acc_q     <= {DATA_W{1'b0}};
         pay_cnt_q     <= {LEN_W{1'b0}};
         trl_q         <= {DATA_W{1'b0}};
         full_byte_q   <= {DATA_W{1'b0}};
         dout_q        <= {DATA_W{1'b0}};
         dout_valid_q  <= 1'b0;
         parity_done_q <= 1'b0;
         pd_prev_q     <= 1'b0;
         lpv_q         <= 1'b0;
         err_q         <= 1'b0;
         len_err_q     <= 1'b0;
         err_count_q   <= {ERRCNT_W{1'b0}};
         laf_prev_q    <= 1'b0;
      end else begin
         hdr_q         <= hdr_d;
         chk_acc_q     <= chk_acc_d;
         pay_cnt_q     <= pay_cnt_d;
         trl_q         <= trl_d;
         full_byte_q   <= full_byte_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         parity_done_q <= parity_done_d;
         pd_prev_q     <= pd_prev_d;
         lpv_q         <= lpv_d;
         err_q         <= err_d;
         len_err_q     <= len_err_d;
         err_count_q   <= err_count_d;
         laf_prev_q    <= laf_prev_d;
      end
   end

   assign dout             = dout_q;
   assign dout_valid       = dout_valid_q;
   assign parity_done      = parity_done_q;
   assign low_packet_valid = lpv_q;
   assign err              = err_q;
   assign len_err          = len_err_q;
   assign err_count        = err_count_q;

endmodule

// File: tb/tb_router_reg_gen2.sv
// Randomised packet bench for router_reg_gen2: one XOR and one CRC instance share stimulus
// and are compared every cycle against a packet-level expectation model.
module tb_router_reg_gen2;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic pkt_valid = 1'b0, fifo_full = 1'b0, detect_add = 1'b0, lfd_state = 1'b0;
   logic ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] x_dout, c_dout, x_cnt, c_cnt;
   logic x_dv, x_pd, x_lpv, x_err, x_len;
   logic c_dv, c_pd, c_lpv, c_err, c_len;

   always #5 clock = ~clock;

   router_reg_gen2 #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHECK_MODE(0),
                     .CRC_POLY(8'h07), .ERRCNT_W(8)) u_xor (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .data_in(data_in), .dout(x_dout), .dout_valid(x_dv), .parity_done(x_pd),
      .low_packet_valid(x_lpv), .err(x_err), .len_err(x_len), .err_count(x_cnt));

   router_reg_gen2 #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHECK_MODE(1),
                     .CRC_POLY(8'h07), .ERRCNT_W(8)) u_crc (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
      .data_in(data_in), .dout(c_dout), .dout_valid(c_dv), .parity_done(c_pd),
      .low_packet_valid(c_lpv), .err(c_err), .len_err(c_len), .err_count(c_cnt));

   typedef logic [7:0] bq_t[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Expected observable state, maintained at packet level by the stimulus code.
   logic [7:0] e_dout = 8'h00, e_cnt_x = 8'h00, e_cnt_c = 8'h00, fb = 8'h00;
   logic e_dv = 1'b0, e_pd = 1'b0, e_lpv = 1'b0, e_len = 1'b0, e_err_x = 1'b0, e_err_c = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xor_msg(input logic [7:0] hdr, input bq_t pay);
      logic [7:0] r;
      r = hdr;
      foreach (pay[i]) r = r ^ pay[i];
      return r;
   endfunction

   // Bit-serial CRC-8, MSB first, poly x^8+x^2+x+1, zero initial value.
   function automatic logic [7:0] crc_msg(input logic [7:0] hdr, input bq_t pay);
      logic [7:0] crc;
      logic [7:0] b;
      logic fbk;
      crc = 8'h00;
      for (int k = -1; k < pay.size(); k++) begin
         b = (k < 0) ? hdr : pay[k];
         for (int j = 7; j >= 0; j--) begin
            fbk = crc[7] ^ b[j];
            crc = {crc[6:0], 1'b0};
            if (fbk) crc = crc ^ 8'h07;
         end
      end
      return crc;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'h01;
   endfunction

   // Per-cycle comparison of both instances against the expectation model.
   always @(negedge clock) begin
      chk("xor.dout", 32'(x_dout), 32'(e_dout));
      chk("xor.dout_valid", 32'(x_dv), 32'(e_dv));
      chk("xor.parity_done", 32'(x_pd), 32'(e_pd));
      chk("xor.low_packet_valid", 32'(x_lpv), 32'(e_lpv));
      chk("xor.err", 32'(x_err), 32'(e_err_x));
      chk("xor.len_err", 32'(x_len), 32'(e_len));
      chk("xor.err_count", 32'(x_cnt), 32'(e_cnt_x));
      chk("crc.dout", 32'(c_dout), 32'(e_dout));
      chk("crc.dout_valid", 32'(c_dv), 32'(e_dv));
      chk("crc.parity_done", 32'(c_pd), 32'(e_pd));
      chk("crc.low_packet_valid", 32'(c_lpv), 32'(e_lpv));
      chk("crc.err", 32'(c_err), 32'(e_err_c));
      chk("crc.len_err", 32'(c_len), 32'(e_len));
      chk("crc.err_count", 32'(c_cnt), 32'(e_cnt_c));
   end

   task automatic step(input bit dv, input logic [7:0] b);
      @(posedge clock);
      #1;
      e_dv = dv;
      if (dv) e_dout = b;
   endtask

   task automatic clear_in();
      pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
      ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
   endtask

   task automatic bad_header(input logic [7:0] h);
      clear_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = h;
      step(1'b0, 8'h00);
      clear_in();
   endtask

   // Plays the FSM through one packet; bit i of fm marks payload byte i as hitting a full FIFO.
   task automatic send_pkt(input logic [7:0] hdr, input bq_t pay, input logic [15:0] fm,
                           input logic [7:0] trl, input bit trl_full, input bit clr_at_trl);
      bit mx, mc, ml;
      clear_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
      step(1'b0, 8'h00);
      e_pd = 1'b0; e_err_x = 1'b0; e_err_c = 1'b0; e_len = 1'b0;
      clear_in(); lfd_state = 1'b1; pkt_valid = 1'b1;
      step(1'b1, hdr);
      foreach (pay[i]) begin
         clear_in(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = pay[i]; fifo_full = fm[i];
         if (!fm[i]) begin
            step(1'b1, pay[i]);
         end else begin
            step(1'b0, 8'h00);
            fb = pay[i];
            clear_in(); fifo_full = 1'b1; full_state = 1'b1;
            repeat ($urandom_range(1, 3)) step(1'b0, 8'h00);
            clear_in(); laf_state = 1'b1; pkt_valid = 1'b1;
            step(1'b1, fb);
            if ($urandom_range(0, 1) == 1) step(1'b0, 8'h00);
         end
      end
      clear_in(); ld_state = 1'b1; data_in = trl; fifo_full = trl_full; rst_int_reg = clr_at_trl;
      step(1'b0, 8'h00);
      e_lpv = !clr_at_trl;
      if (!trl_full) begin
         e_pd = 1'b1;
      end else begin
         clear_in(); fifo_full = 1'b1; full_state = 1'b1;
         step(1'b0, 8'h00);
         clear_in(); laf_state = 1'b1;
         step(1'b1, fb);
         e_pd = e_lpv;
      end
      clear_in();
      step(1'b0, 8'h00);
      if (e_pd) begin
         mx = (xor_msg(hdr, pay) != trl);
         mc = (crc_msg(hdr, pay) != trl);
         ml = (pay.size() != int'(hdr[7:2]));
         e_err_x = mx; e_err_c = mc; e_len = ml;
         if (mx || ml) e_cnt_x = sat_inc(e_cnt_x);
         if (mc || ml) e_cnt_c = sat_inc(e_cnt_c);
      end
      rst_int_reg = 1'b1;
      step(1'b0, 8'h00);
      rst_int_reg = 1'b0;
      e_lpv = 1'b0;
   endtask

   initial begin
      bq_t pay;
      logic [7:0] h, t;
      logic [15:0] fm;
      int len, np, kind;
      bit tf, clr;

      clear_in();
      resetn = 1'b0;
      repeat (2) step(1'b0, 8'h00);
      resetn = 1'b1;
      step(1'b0, 8'h00);

      // Model pins against hand-computed values.
      pay.delete(); pay.push_back(8'hA1); pay.push_back(8'h5C); pay.push_back(8'h33);
      chk("pin_xor_0D_A1_5C_33", 32'(xor_msg(8'h0D, pay)), 32'h0000_00C3);
      pay.delete(); pay.push_back(8'h31);
      chk("pin_crc_05_31", 32'(crc_msg(8'h05, pay)), 32'h0000_00D6);
      chk("pin_xor_05_31", 32'(xor_msg(8'h05, pay)), 32'h0000_0034);
      chk("reset_cnt", 32'(x_cnt), 32'd0);

      // 1: good XOR packet.
      pay.delete(); pay.push_back(8'hA1); pay.push_back(8'h5C); pay.push_back(8'h33);
      send_pkt(8'h0D, pay, 16'h0000, 8'hC3, 1'b0, 1'b0);
      chk("t1_err", 32'(x_err), 32'd0);
      chk("t1_len_err", 32'(x_len), 32'd0);
      chk("t1_cnt", 32'(x_cnt), 32'd0);
      // 2: inverted trailer.
      send_pkt(8'h0D, pay, 16'h0000, 8'h3C, 1'b0, 1'b0);
      chk("t2_err", 32'(x_err), 32'd1);
      chk("t2_cnt", 32'(x_cnt), 32'd1);
      // 3: FIFO full on the second payload byte.
      send_pkt(8'h0D, pay, 16'h0002, 8'hC3, 1'b0, 1'b0);
      chk("t3_err", 32'(x_err), 32'd0);
      chk("t3_cnt", 32'(x_cnt), 32'd1);
      // 4: CRC good then one bit corrupted.
      pay.delete(); pay.push_back(8'h31);
      send_pkt(8'h05, pay, 16'h0000, 8'hD6, 1'b0, 1'b0);
      chk("t4_crc_err_good", 32'(c_err), 32'd0);
      send_pkt(8'h05, pay, 16'h0000, 8'hD7, 1'b0, 1'b0);
      chk("t4_crc_err_bad", 32'(c_err), 32'd1);
      chk("t4_xor_cnt", 32'(x_cnt), 32'd3);
      // 5: short payload.
      pay.delete(); pay.push_back(8'hA1); pay.push_back(8'h5C);
      send_pkt(8'h0D, pay, 16'h0000, 8'hF0, 1'b0, 1'b0);
      chk("t5_len_err", 32'(x_len), 32'd1);
      chk("t5_err", 32'(x_err), 32'd0);
      chk("t5_cnt", 32'(x_cnt), 32'd4);
      // 6a: invalid address holds everything.
      bad_header(8'h0F);
      step(1'b0, 8'h00);
      chk("t6_hold_len_err", 32'(x_len), 32'd1);
      chk("t6_hold_dout", 32'(x_dout), 32'h0000_00F0 ^ 32'h0000_00AC);

      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(0, 6);
         kind = $urandom_range(0, 3);
         np = len;
         if (kind == 0 && len > 0) np = len - 1;
         else if (kind == 1) np = len + 1;
         h = {len[5:0], 2'($urandom_range(0, 2))};
         pay.delete();
         fm = 16'h0000;
         for (int i = 0; i < np; i++) begin
            pay.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) fm[i] = 1'b1;
         end
         kind = $urandom_range(0, 2);
         t = (kind == 0) ? xor_msg(h, pay) : (kind == 1) ? crc_msg(h, pay) : 8'($urandom_range(0, 255));
         tf = ($urandom_range(0, 3) == 0);
         clr = !tf && ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) bad_header({6'($urandom_range(0, 63)), 2'b11});
         send_pkt(h, pay, fm, t, tf, clr);
         repeat ($urandom_range(0, 2)) step(1'b0, 8'h00);
      end

      // 6b: asynchronous reset mid-payload.
      clear_in(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h09;
      step(1'b0, 8'h00);
      e_pd = 1'b0; e_err_x = 1'b0; e_err_c = 1'b0; e_len = 1'b0;
      clear_in(); lfd_state = 1'b1; pkt_valid = 1'b1;
      step(1'b1, 8'h09);
      clear_in(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h77;
      step(1'b1, 8'h77);
      resetn = 1'b0;
      e_dout = 8'h00; e_dv = 1'b0; e_pd = 1'b0; e_lpv = 1'b0; e_len = 1'b0;
      e_err_x = 1'b0; e_err_c = 1'b0; e_cnt_x = 8'h00; e_cnt_c = 8'h00; fb = 8'h00;
      #1;
      chk("t6_rst_dout", 32'(x_dout), 32'd0);
      chk("t6_rst_dout_valid", 32'(x_dv), 32'd0);
      chk("t6_rst_xor_cnt", 32'(x_cnt), 32'd0);
      chk("t6_rst_crc_cnt", 32'(c_cnt), 32'd0);
      clear_in();
      step(1'b0, 8'h00);
      resetn = 1'b1;
      step(1'b0, 8'h00);

      // Trailer under a full FIFO: completion deferred to the replay cycle.
      pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22);
      send_pkt(8'h0A, pay, 16'h0000, xor_msg(8'h0A, pay), 1'b1, 1'b0);
      chk("fin_parity_done", 32'(x_pd), 32'd1);
      chk("fin_err", 32'(x_err), 32'd0);
      chk("fin_cnt", 32'(x_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
